// File: rtl/shift_sequencer.sv
// Multi-cycle shift initiator: applies the single-step shifter op once per cycle
// for a captured amount, then raises a one-cycle done pulse.
module shift_sequencer #(
   parameter int N     = 4,
   parameter int AMT_W = 3
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic [1:0]       op,
   input  logic [N-1:0]     din,
   input  logic [AMT_W-1:0] amt,
   output logic             busy,
   output logic             done,
   output logic [N-1:0]     dout
);

   typedef enum logic [1:0] {
      IDLE,
      SHIFT,
      DONE
   } state_t;

   state_t           state;
   logic [1:0]       op_q;
   logic [AMT_W-1:0] count;

   // One application of the datapath's single-step shifter; shift-in is always 0.
   function automatic logic [N-1:0] step(input logic [1:0] code, input logic [N-1:0] v);
      case (code)
         2'b00:   return {v[N-2:0], 1'b0};
         2'b01:   return v;
         2'b10:   return {1'b0, v[N-1:1]};
         default: return '0;
      endcase
   endfunction

   // busy/done are registered from the next state so they line up exactly with SHIFT/DONE.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state <= IDLE;
         op_q  <= 2'b00;
         count <= '0;
         dout  <= '0;
         busy  <= 1'b0;
         done  <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (start) begin
                  op_q  <= op;
                  count <= amt;
                  busy  <= 1'b1;
                  if (op == 2'b11) begin
                     dout  <= '0;
                     state <= DONE;
                     done  <= 1'b1;
                  end else if (op == 2'b01 || amt == '0) begin
                     dout  <= din;
                     state <= DONE;
                     done  <= 1'b1;
                  end else begin
                     dout  <= din;
                     state <= SHIFT;
                     done  <= 1'b0;
                  end
               end
            end
            SHIFT: begin
               dout  <= step(op_q, dout);
               count <= count - AMT_W'(1);
               if (count == AMT_W'(1)) begin
                  state <= DONE;
                  done  <= 1'b1;
               end
            end
            DONE: begin
               state <= IDLE;
               busy  <= 1'b0;
               done  <= 1'b0;
            end
            default: begin
               state <= IDLE;
               busy  <= 1'b0;
               done  <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_shift_sequencer.sv
// Self-checking bench for shift_sequencer: directed cases plus random operations
// compared against an arithmetic reference of the final result and latency.
module tb_shift_sequencer;

   localparam int N     = 4;
   localparam int AMT_W = 3;

   logic             clk = 1'b0;
   logic             rst;
   logic             start;
   logic [1:0]       op;
   logic [N-1:0]     din;
   logic [AMT_W-1:0] amt;
   logic             busy;
   logic             done;
   logic [N-1:0]     dout;

   int assert_cnt = 0;
   int fail_cnt   = 0;

   shift_sequencer #(.N(N), .AMT_W(AMT_W)) dut (
      .clk   (clk),
      .rst   (rst),
      .start (start),
      .op    (op),
      .din   (din),
      .amt   (amt),
      .busy  (busy),
      .done  (done),
      .dout  (dout)
   );

   always #5 clk = ~clk;

   task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      assert_cnt++;
      assert (obs === exp) else begin
         fail_cnt++;
         $error("[TB] FAIL %s: observed %0h, expected %0h", tag, obs, exp);
      end
   endtask

   // Reference: the result of applying a one-bit step amt times is a plain shift by amt.
   function automatic logic [31:0] modelResult(input logic [1:0] m_op, input logic [N-1:0] m_din,
                                               input logic [AMT_W-1:0] m_amt);
      int v;
      v = int'(m_din);
      case (m_op)
         2'b00:   v = (v << m_amt) & ((1 << N) - 1);
         2'b10:   v = v >> m_amt;
         2'b01:   v = v;
         default: v = 0;
      endcase
      return 32'(v);
   endfunction

   function automatic int modelBusyCycles(input logic [1:0] m_op, input logic [AMT_W-1:0] m_amt);
      if ((m_op == 2'b00 || m_op == 2'b10) && m_amt != 0)
         return int'(m_amt) + 1;
      return 1;
   endfunction

   // Must be called at a negedge with the DUT idle; returns at the negedge where busy drops.
   task automatic applyStimulus(input string tag, input logic [1:0] s_op, input logic [N-1:0] s_din,
                                input logic [AMT_W-1:0] s_amt, input bit inject);
      int busy_cnt;
      int done_cnt;
      int done_at;
      bit ended;
      logic [31:0] exp_res;
      int exp_lat;
      exp_res = modelResult(s_op, s_din, s_amt);
      exp_lat = modelBusyCycles(s_op, s_amt);
      start = 1'b1;
      op    = s_op;
      din   = s_din;
      amt   = s_amt;
      @(posedge clk);
      #1;
      start = 1'b0;
      op    = 2'($urandom);
      din   = N'($urandom);
      amt   = AMT_W'($urandom);
      busy_cnt = 0;
      done_cnt = 0;
      done_at  = 0;
      ended    = 1'b0;
      for (int i = 0; i < 20; i++) begin
         @(negedge clk);
         if (!busy) begin
            ended = 1'b1;
            break;
         end
         busy_cnt++;
         if (done) begin
            done_cnt++;
            done_at = busy_cnt;
         end
         if (inject && busy_cnt == 1) begin
            start = 1'b1;
            din   = '0;
            op    = 2'b01;
            amt   = '0;
         end else begin
            start = 1'b0;
         end
      end
      start = 1'b0;
      checkOutput({tag, " terminated"}, 32'(ended), 32'd1);
      checkOutput({tag, " busy cycles"}, 32'(busy_cnt), 32'(exp_lat));
      checkOutput({tag, " done pulses"}, 32'(done_cnt), 32'd1);
      checkOutput({tag, " done position"}, 32'(done_at), 32'(exp_lat));
      checkOutput({tag, " dout"}, 32'(dout), exp_res);
      checkOutput({tag, " done idle"}, 32'(done), 32'd0);
   endtask

   initial begin
      int idle_done;
      rst   = 1'b1;
      start = 1'b0;
      op    = 2'b00;
      din   = '0;
      amt   = '0;
      #1;
      checkOutput("reset dout", 32'(dout), 32'd0);
      checkOutput("reset busy", 32'(busy), 32'd0);
      checkOutput("reset done", 32'(done), 32'd0);
      #20;
      @(negedge clk);
      rst = 1'b0;
      @(negedge clk);

      applyStimulus("case1 shl amt1", 2'b00, 4'b0011, 3'd1, 1'b0);
      applyStimulus("case2 shr amt3", 2'b10, 4'b1001, 3'd3, 1'b0);
      applyStimulus("case3 shl amt5", 2'b00, 4'b1111, 3'd5, 1'b0);
      applyStimulus("case4 pass", 2'b01, 4'b1010, 3'd7, 1'b0);
      applyStimulus("case4 clear", 2'b11, 4'b1111, 3'd0, 1'b0);
      applyStimulus("amt0 shr", 2'b10, 4'b1011, 3'd0, 1'b0);
      applyStimulus("case5 start ignored", 2'b10, 4'b1001, 3'd3, 1'b1);

      // Asynchronous reset in the middle of a shift, away from any clock edge.
      start = 1'b1;
      op    = 2'b10;
      din   = 4'b1001;
      amt   = 3'd3;
      @(posedge clk);
      #1;
      start = 1'b0;
      @(posedge clk);
      #2;
      rst = 1'b1;
      #1;
      checkOutput("case6 rst dout", 32'(dout), 32'd0);
      checkOutput("case6 rst busy", 32'(busy), 32'd0);
      checkOutput("case6 rst done", 32'(done), 32'd0);
      @(negedge clk);
      rst = 1'b0;
      idle_done = 0;
      for (int i = 0; i < 6; i++) begin
         @(negedge clk);
         if (done || busy) idle_done++;
      end
      checkOutput("case6 quiet after reset", 32'(idle_done), 32'd0);
      applyStimulus("case6 restart", 2'b00, 4'b0101, 3'd2, 1'b0);

      for (int i = 0; i < 30; i++) begin
         applyStimulus("random", 2'($urandom), N'($urandom), AMT_W'($urandom), 1'($urandom_range(0, 1)));
      end

      $display("End of test - %0d assertions evaluated, %0d failures", assert_cnt, fail_cnt);
      $finish;
   end

endmodule
